border_pad: RTL and testbench
=============================

Name: border_pad

Overview:
- ISP stream stage that is the inverse of the crop stage: it embeds an incoming in_x × in_y frame into a larger out_x × out_y output frame at (offset_x, offset_y).
- Every output position outside the embedded window is filled with a constant pad colour.
- Uses the same 3-channel data, 8-bit user sideband (bit1 = frame start, bit0 = line start), valid/ready handshake and isp_* register interface as the other pipeline stages.
- Sits after crop/scale stages, ahead of the display/output formatter.

Parameters:
COLOR_DEPTH, 16, bits per colour channel

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
in_data  input  COLOR_DEPTH×3  upstream pixel
in_user  input  8  upstream sideband; [1] fstart, [0] hstart, [7:2] pass-through
in_valid  input  1  upstream pixel valid
out_ready  output  1  this block accepts an upstream pixel this cycle
out_data  output  COLOR_DEPTH×3  downstream pixel
out_user  output  8  downstream sideband
out_valid  output  1  downstream pixel valid
in_ready  input  1  downstream accepts this cycle
isp_ctrl  input  16  [0] global enable, [9] pad enable
isp_in_pixel_x / isp_in_pixel_y  input  16 each  input frame size
isp_out_offset_x / isp_out_offset_y  input  16 each  window origin inside the output frame
isp_out_pixel_x / isp_out_pixel_y  input  16 each  output frame size
pad_data  input  COLOR_DEPTH×3  fill colour
err_resync  output  1  one-cycle pulse when a frame is aborted

Behaviour:
- Single clock domain. Reset is asynchronous, active-high.
- Reset values:
  - out_valid = 0, out_data = 0, out_user = 0, err_resync = 0.
  - FSM = IDLE, counters = 0.
- Config registers:
  - All isp_* inputs are registered every cycle.
  - The working copy (sizes, offsets, enable, cfg_ok) is latched only on entry to RUN, so it is stable for a whole frame.
  - pad_data is latched at the same point.
- Output stage:
  - One register stage; it advances when ~out_valid | in_ready.
  - Latency from an accepted input pixel to out_valid is 1 cycle.
- Bypass (enable = isp_ctrl[9] & isp_ctrl[0] is 0, or the latched cfg_ok is 0):
  - in_data and in_user pass through the output register unchanged.
  - out_ready = advance.
- cfg_ok requires all of the following, computed in 17-bit arithmetic with no wrap:
  - in_x ≥ 1, in_y ≥ 1
  - offset_x + in_x ≤ out_x
  - offset_y + in_y ≤ out_y
- FSM states (pad mode):
  - IDLE:
    - Peek at the input. If in_valid & in_fstart, latch config and in_user[7:2] into user_hi, set ox = oy = 0, go to RUN without consuming the pixel.
    - Any in_valid pixel without fstart is consumed and discarded (out_ready = 1).
  - RUN: each time advance is true, emit position (ox, oy).
    - Inside the window [offset_x, offset_x+in_x) × [offset_y, offset_y+in_y):
      - Requires in_valid; the input is consumed (out_ready = advance).
      - out_data = in_data; user_hi is updated from in_user[7:2].
      - If in_valid = 0, stall (out_valid drops next cycle).
    - Outside the window:
      - out_data = pad_data; out_ready = 0; no input is needed.
    - Output sideband for every emitted pixel:
      - out_user = {user_hi, fstart, hstart}
      - fstart = (ox == 0 && oy == 0)
      - hstart = (ox == 0)
    - Raster order: ox increments; at out_x-1, ox wraps to 0 and oy increments.
    - After emitting (out_x-1, out_y-1), go to IDLE.
  - Resync:
    - Trigger: in RUN, at a window position other than (offset_x, offset_y), with in_valid & in_fstart.
    - The pixel is not consumed. err_resync pulses for 1 cycle.
    - FSM goes to IDLE, which immediately restarts on that pixel.
    - The partial output frame is truncated, with no padding to completion.
- Enable change mid-frame takes effect only at the next IDLE→RUN transition.
- Backpressure: with in_ready = 0 and out_valid = 1, out_data and out_user hold stable and no counter advances.
- Counters are 16-bit. Window bounds are precomputed as 17-bit registered sums at frame start.

Decomposition:
- Shared ISP package holds:
  - user-bit index constants: USER_FSTART = 1, USER_HSTART = 0
  - isp_ctrl bit constants: CTRL_EN = 0, CTRL_PAD_EN = 9
  - the FSM state enum {IDLE, RUN}
- One natural sub-module, pad_raster_cnt: holds the ox/oy counters, the window-hit compare and the end-of-frame flag.

Test Plan:
- Pad, in 4×2, out 6×4, offset (1,1), pad = 0x0AAA, in_ready = 1:
  - exactly 24 outputs.
  - Row 0: all pad.
  - Rows 1–2: pad, 4 input pixels in order, pad.
  - Row 3: all pad.
  - fstart only on output #0; hstart on outputs #0, 6, 12, 18.
- Same config with random in_ready and in_valid gaps:
  - identical output sequence.
  - out_data and out_user stable while out_valid & ~in_ready.
  - no input pixel lost or duplicated.
- Bypass (isp_ctrl[9] = 0): 8 pixels in → the same 8 out with in_user unchanged, 1-cycle latency.
- Illegal config (offset_x = 3, in_x = 4, out_x = 6):
  - cfg_ok = 0, frame passes through as bypass.
  - 8 outputs, no pad.
- Inject fstart on the 3rd input pixel of a frame:
  - err_resync pulses once.
  - The new frame starts and emits a fresh 24-pixel sequence beginning with fstart.
- Assert reset mid-frame (asynchronously): out_valid goes to 0 immediately, FSM is IDLE, and the next fstart produces a complete frame.

Source files
------------

// File: rtl/border_pad_pkg.sv
// Shared constants and types for the border_pad stream stage.
// Sideband bit positions, control bit positions and the frame FSM states.
package border_pad_pkg;
    localparam int USER_FSTART = 1;
    localparam int USER_HSTART = 0;
    localparam int CTRL_EN     = 0;
    localparam int CTRL_PAD_EN = 9;

    typedef enum logic {IDLE, RUN} state_t;
endpackage

// File: rtl/border_pad_if.sv
// Pixel stream bundle: upstream pixel in / downstream pixel out with valid/ready.
// Port names follow the pipeline's existing naming (out_ready faces upstream, in_ready faces downstream).
interface border_pad_if #(parameter int COLOR_DEPTH = 16);
    logic [3*COLOR_DEPTH-1:0] in_data;
    logic [7:0]               in_user;
    logic                     in_valid;
    logic                     out_ready;
    logic [3*COLOR_DEPTH-1:0] out_data;
    logic [7:0]               out_user;
    logic                     out_valid;
    logic                     in_ready;

    modport master (output in_data, in_user, in_valid, in_ready,
                    input  out_ready, out_data, out_user, out_valid);
    modport slave  (input  in_data, in_user, in_valid, in_ready,
                    output out_ready, out_data, out_user, out_valid);
endinterface

// File: rtl/border_pad_raster_cnt.sv
// Output raster position counters plus window-hit, origin and end-of-frame flags.
module pad_raster_cnt
    import border_pad_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        step,
    input  logic [15:0] out_x,
    input  logic [15:0] out_y,
    input  logic [15:0] off_x,
    input  logic [15:0] off_y,
    input  logic [16:0] end_x,
    input  logic [16:0] end_y,
    output logic [15:0] ox,
    output logic [15:0] oy,
    output logic        win,
    output logic        at_origin,
    output logic        eof
);
    logic [15:0] ox_q, ox_d, oy_q, oy_d;
    logic        last_col;

    always_comb begin
        last_col = (ox_q == out_x - 16'd1);
        ox_d     = ox_q;
        oy_d     = oy_q;
        if (clr) begin
            ox_d = '0;
            oy_d = '0;
        end else if (step) begin
            if (last_col) begin
                ox_d = '0;
                oy_d = oy_q + 16'd1;
            end else begin
                ox_d = ox_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ox_q <= '0;
            oy_q <= '0;
        end else begin
            ox_q <= ox_d;
            oy_q <= oy_d;
        end
    end

    // end bounds are 17-bit so a window touching 0xFFFF never wraps
    assign win       = (ox_q >= off_x) && ({1'b0, ox_q} < end_x) &&
                       (oy_q >= off_y) && ({1'b0, oy_q} < end_y);
    assign at_origin = (ox_q == off_x) && (oy_q == off_y);
    assign eof       = last_col && (oy_q == out_y - 16'd1);
    assign ox        = ox_q;
    assign oy        = oy_q;
endmodule

// File: rtl/border_pad.sv
// Embeds an in_x*in_y frame at (offset_x, offset_y) inside an out_x*out_y frame filled with pad colour.
// Falls back to straight pass-through when padding is disabled or the geometry does not fit.
module border_pad
    import border_pad_pkg::*;
#(
    parameter int COLOR_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    border_pad_if.slave              s,
    input  logic [15:0]              isp_ctrl,
    input  logic [15:0]              isp_in_pixel_x,
    input  logic [15:0]              isp_in_pixel_y,
    input  logic [15:0]              isp_out_offset_x,
    input  logic [15:0]              isp_out_offset_y,
    input  logic [15:0]              isp_out_pixel_x,
    input  logic [15:0]              isp_out_pixel_y,
    input  logic [3*COLOR_DEPTH-1:0] pad_data,
    output logic                     err_resync
);
    localparam int DW = 3 * COLOR_DEPTH;

    logic          isp_en_q;
    logic [15:0]   isp_in_x_q, isp_in_y_q, isp_off_x_q, isp_off_y_q, isp_out_x_q, isp_out_y_q;
    logic [15:0]   off_x_q, off_y_q, out_x_q, out_y_q;
    logic [16:0]   end_x_q, end_y_q, sum_x, sum_y;
    logic [DW-1:0] pad_q;
    logic          cfg_ok, cand_act, ctrl_unused;

    state_t        state_q, state_d;
    logic          pad_act_q, pad_act_d, err_q, err_d, out_valid_q, out_valid_d;
    logic [5:0]    user_hi_q, user_hi_d;
    logic [DW-1:0] out_data_q, out_data_d, emit_data;
    logic [7:0]    out_user_q, out_user_d, emit_user;
    logic          advance, start, ready, latch, emit, cnt_step, fs, hs;
    logic [15:0]   ox, oy;
    logic          win, at_origin, eof;

    assign ctrl_unused = &{1'b0, isp_ctrl[15:10], isp_ctrl[8:1]};

    assign sum_x    = {1'b0, isp_off_x_q} + {1'b0, isp_in_x_q};
    assign sum_y    = {1'b0, isp_off_y_q} + {1'b0, isp_in_y_q};
    assign cfg_ok   = (isp_in_x_q != 16'd0) && (isp_in_y_q != 16'd0) &&
                      (sum_x <= {1'b0, isp_out_x_q}) && (sum_y <= {1'b0, isp_out_y_q});
    assign cand_act = isp_en_q & cfg_ok;

    pad_raster_cnt u_cnt (
        .clk      (clk),
        .reset    (reset),
        .clr      (latch),
        .step     (cnt_step),
        .out_x    (out_x_q),
        .out_y    (out_y_q),
        .off_x    (off_x_q),
        .off_y    (off_y_q),
        .end_x    (end_x_q),
        .end_y    (end_y_q),
        .ox       (ox),
        .oy       (oy),
        .win      (win),
        .at_origin(at_origin),
        .eof      (eof)
    );

    assign fs = (ox == 16'd0) && (oy == 16'd0);
    assign hs = (ox == 16'd0);

    always_comb begin
        advance     = ~out_valid_q | s.in_ready;
        start       = s.in_valid & s.in_user[USER_FSTART];
        state_d     = state_q;
        pad_act_d   = pad_act_q;
        user_hi_d   = user_hi_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_user_d  = out_user_q;
        err_d       = 1'b0;
        ready       = 1'b0;
        latch       = 1'b0;
        cnt_step    = 1'b0;
        emit        = 1'b0;
        emit_data   = s.in_data;
        emit_user   = s.in_user;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // frame boundary: snapshot config; a padded frame starts without consuming the pixel
                    latch     = 1'b1;
                    pad_act_d = cand_act;
                    user_hi_d = s.in_user[7:2];
                    if (cand_act) begin
                        state_d = RUN;
                    end else begin
                        ready = advance;
                        emit  = 1'b1;
                    end
                end else if (pad_act_q) begin
                    ready = 1'b1;
                end else begin
                    ready = advance;
                    emit  = s.in_valid;
                end
            end
            RUN: begin
                if (win && !at_origin && start) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (advance) begin
                    if (win) begin
                        if (s.in_valid) begin
                            ready     = 1'b1;
                            emit      = 1'b1;
                            cnt_step  = 1'b1;
                            user_hi_d = s.in_user[7:2];
                            emit_user = {s.in_user[7:2], fs, hs};
                        end
                    end else begin
                        emit      = 1'b1;
                        cnt_step  = 1'b1;
                        emit_data = pad_q;
                        emit_user = {user_hi_q, fs, hs};
                    end
                    if (cnt_step && eof) state_d = IDLE;
                end
            end
        endcase
        if (advance) begin
            out_valid_d = emit;
            if (emit) begin
                out_data_d = emit_data;
                out_user_d = emit_user;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            isp_en_q    <= 1'b0;
            isp_in_x_q  <= '0;
            isp_in_y_q  <= '0;
            isp_off_x_q <= '0;
            isp_off_y_q <= '0;
            isp_out_x_q <= '0;
            isp_out_y_q <= '0;
            off_x_q     <= '0;
            off_y_q     <= '0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            end_x_q     <= '0;
            end_y_q     <= '0;
            pad_q       <= '0;
            state_q     <= IDLE;
            pad_act_q   <= 1'b0;
            user_hi_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_user_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            isp_en_q    <= isp_ctrl[CTRL_EN] & isp_ctrl[CTRL_PAD_EN];
            isp_in_x_q  <= isp_in_pixel_x;
            isp_in_y_q  <= isp_in_pixel_y;
            isp_off_x_q <= isp_out_offset_x;
            isp_off_y_q <= isp_out_offset_y;
            isp_out_x_q <= isp_out_pixel_x;
            isp_out_y_q <= isp_out_pixel_y;
            if (latch) begin
                off_x_q <= isp_off_x_q;
                off_y_q <= isp_off_y_q;
                out_x_q <= isp_out_x_q;
                out_y_q <= isp_out_y_q;
                end_x_q <= sum_x;
                end_y_q <= sum_y;
                pad_q   <= pad_data;
            end
            state_q     <= state_d;
            pad_act_q   <= pad_act_d;
            user_hi_q   <= user_hi_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_user_q  <= out_user_d;
            err_q       <= err_d;
        end
    end

    assign s.out_ready = ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_user  = out_user_q;
    assign err_resync  = err_q;
endmodule

// File: tb/tb_border_pad.sv
// Randomised self-checking bench for border_pad against a raster-walk reference model.
module tb_border_pad;
    localparam int CD = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] isp_ctrl, isp_ix, isp_iy, isp_offx, isp_offy, isp_ox, isp_oy;
    logic [47:0] pad;
    logic        err_resync;

    always #5 clk = ~clk;

    border_pad_if #(.COLOR_DEPTH(CD)) bus();

    border_pad #(.COLOR_DEPTH(CD)) dut (
        .clk             (clk),
        .reset           (reset),
        .s               (bus),
        .isp_ctrl        (isp_ctrl),
        .isp_in_pixel_x  (isp_ix),
        .isp_in_pixel_y  (isp_iy),
        .isp_out_offset_x(isp_offx),
        .isp_out_offset_y(isp_offy),
        .isp_out_pixel_x (isp_ox),
        .isp_out_pixel_y (isp_oy),
        .pad_data        (pad),
        .err_resync      (err_resync)
    );

    int          n_chk = 0, n_err = 0, cyc_n = 0, n_resync = 0;
    bit          rnd = 1'b0;
    bit          prev_stall = 1'b0;
    logic [55:0] prev_out;
    logic [55:0] src[$], frm[$], expq[$], got[$];
    int          acc_c[$], out_c[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // one clock: drive at negedge, sample just after, record transfers due at the next posedge
    task automatic cyc();
        @(negedge clk);
        bus.in_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (src.size() > 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            bus.in_valid = 1'b1;
            bus.in_data  = src[0][55:8];
            bus.in_user  = src[0][7:0];
        end else begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
            bus.in_user  = '0;
        end
        #1;
        if (prev_stall)
            chk("hold", 64'({1'b1, prev_out}), 64'({bus.out_valid, bus.out_data, bus.out_user}));
        prev_stall = bus.out_valid & ~bus.in_ready;
        prev_out   = {bus.out_data, bus.out_user};
        if (bus.out_valid && bus.in_ready) begin
            got.push_back({bus.out_data, bus.out_user});
            out_c.push_back(cyc_n);
        end
        if (bus.in_valid && bus.out_ready) begin
            void'(src.pop_front());
            acc_c.push_back(cyc_n);
        end
        if (err_resync) n_resync++;
        cyc_n++;
    endtask

    task automatic set_cfg(input logic [15:0] c, ix, iy, x0, y0, w, h);
        isp_ctrl = c; isp_ix = ix; isp_iy = iy;
        isp_offx = x0; isp_offy = y0; isp_ox = w; isp_oy = h;
        repeat (3) cyc();
    endtask

    task automatic clr();
        got.delete(); expq.delete(); acc_c.delete(); out_c.delete();
    endtask

    task automatic gen(input int n, input int w);
        frm.delete();
        for (int i = 0; i < n; i++) begin
            logic [63:0] r;
            logic [7:0]  u;
            r    = {$urandom, $urandom};
            u    = 8'($urandom);
            u[1] = (i == 0);
            u[0] = (i % w == 0);
            frm.push_back({r[47:0], u});
        end
    endtask

    task automatic feed(input int n);
        for (int i = 0; i < n; i++) src.push_back(frm[i]);
    endtask

    // walk the output raster; window spots take the next input pixel, the rest get pad
    task automatic model_pad(input int ix, iy, x0, y0, w, h, input int n_avail);
        int         k;
        logic [5:0] hi;
        k  = 0;
        hi = frm[0][7:2];
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) begin
                logic fs, hs;
                fs = (x == 0 && y == 0);
                hs = (x == 0);
                if (x >= x0 && x < x0 + ix && y >= y0 && y < y0 + iy) begin
                    if (k >= n_avail) return;
                    hi = frm[k][7:2];
                    expq.push_back({frm[k][55:8], hi, fs, hs});
                    k++;
                end else begin
                    expq.push_back({pad, hi, fs, hs});
                end
            end
        end
    endtask

    task automatic run_cmp(input string tag, input int budget);
        int b;
        b = 0;
        while (got.size() < expq.size() && b < budget) begin
            cyc();
            b++;
        end
        if (b >= budget) chk({tag, "_timeout"}, 64'(got.size()), 64'(expq.size()));
        repeat (12) cyc();
        chk({tag, "_cnt"}, 64'(got.size()), 64'(expq.size()));
        for (int i = 0; i < expq.size() && i < got.size(); i++)
            chk(tag, 64'(got[i]), 64'(expq[i]));
    endtask

    initial begin
        int fs_n, hs_bad;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_ready = 1'b1; bus.in_data = '0; bus.in_user = '0;
        isp_ctrl = '0; isp_ix = '0; isp_iy = '0; isp_offx = '0; isp_offy = '0;
        isp_ox = '0; isp_oy = '0;
        pad = {3{16'h0AAA}};
        #12;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_user", 64'(bus.out_user), 64'd0);
        chk("rst_err", 64'(err_resync), 64'd0);
        @(negedge clk);
        reset = 1'b0;

        // padded frame, no stalls
        set_cfg(16'h0201, 4, 2, 1, 1, 6, 4);
        clr(); gen(8, 4); feed(8); model_pad(4, 2, 1, 1, 6, 4, 8);
        run_cmp("pad", 400);
        fs_n = 0; hs_bad = 0;
        for (int i = 0; i < got.size(); i++) begin
            fs_n   += int'(got[i][1]);
            hs_bad += int'(got[i][0] != (i % 6 == 0));
        end
        chk("pad_fs_cnt", 64'(fs_n), 64'd1);
        chk("pad_hs_pos", 64'(hs_bad), 64'd0);
        if (got.size() > 7) begin
            chk("pad_first", 64'(got[0][55:8]), 64'(pad));
            chk("pad_win0", 64'(got[7][55:8]), 64'(frm[0][55:8]));
        end
        chk("pad_no_resync", 64'(n_resync), 64'd0);

        // same frame with random gaps both sides
        rnd = 1'b1;
        clr(); gen(8, 4); feed(8); model_pad(4, 2, 1, 1, 6, 4, 8);
        run_cmp("pad_rnd", 3000);

        // pad disabled: pass-through with one-cycle latency
        rnd = 1'b0;
        set_cfg(16'h0001, 4, 2, 1, 1, 6, 4);
        clr(); gen(8, 4); feed(8);
        foreach (frm[i]) expq.push_back(frm[i]);
        run_cmp("byp", 200);
        for (int i = 0; i < out_c.size() && i < acc_c.size(); i++)
            chk("byp_lat", 64'(out_c[i] - acc_c[i]), 64'd1);

        // window does not fit horizontally -> pass-through
        rnd = 1'b1;
        set_cfg(16'h0201, 4, 2, 3, 1, 6, 4);
        clr(); gen(8, 4); feed(8);
        foreach (frm[i]) expq.push_back(frm[i]);
        run_cmp("illegal", 2000);

        // new frame start arrives as the 3rd pixel of the current one
        set_cfg(16'h0201, 4, 2, 1, 1, 6, 4);
        clr(); n_resync = 0;
        gen(8, 4); feed(2); model_pad(4, 2, 1, 1, 6, 4, 2);
        gen(8, 4); feed(8); model_pad(4, 2, 1, 1, 6, 4, 8);
        run_cmp("resync", 3000);
        chk("resync_pulse", 64'(n_resync), 64'd1);

        // asynchronous reset in the middle of a padded frame
        rnd = 1'b0;
        clr(); gen(8, 4); feed(8);
        repeat (10) cyc();
        chk("pre_rst_valid", 64'(bus.out_valid), 64'd1);
        #1 reset = 1'b1;
        #1 chk("arst_valid", 64'(bus.out_valid), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        prev_stall = 1'b0;
        src.delete(); clr();
        repeat (3) cyc();
        clr(); gen(8, 4); feed(8); model_pad(4, 2, 1, 1, 6, 4, 8);
        run_cmp("post_rst", 400);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
